// File: rtl/rx_crc_checker.sv
// RX CRC-32/BZIP2 checker: strips the trailing 4-byte FCS, forwards payload, one status strobe per frame.
// Optional build macro RX_FCS_PASS_EN: forward every byte (FCS included) one cycle after acceptance.
module rx_crc_checker #(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    input  logic        data_last,
    input  logic        rx_abort,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic        frame_done,
    output logic        crc_ok,
    output logic        crc_err,
    output logic        len_err,
    output logic [15:0] frame_len
);

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [15:0] LEN_MIN  = 16'(MIN_FRAME);
    localparam logic [15:0] LEN_MAX  = 16'(MAX_FRAME);
    localparam logic [15:0] LEN_SAT  = 16'(MAX_FRAME + 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DISCARD
    } state_t;

    state_t      state;
    logic [31:0] crc_reg;
    logic [15:0] byte_cnt;
    logic [7:0]  sr [4];
    logic [2:0]  fill;

    logic        aborting;
    logic        accept;
    logic        window_full;
    logic        over_max;
    logic        fcs_match;
    logic        len_bad;
    logic        abort_len_bad;
    logic [15:0] cnt_next;
    logic [31:0] crc_next;
    logic [31:0] fcs_rx;

    // MSB-first bit-serial update, unrolled over one byte
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = r[31] ^ d[3'(7 - i)];
            r  = {r[30:0], 1'b0};
            if (fb) begin
                r = r ^ CRC_POLY;
            end
        end
        return r;
    endfunction

    always_comb begin
        aborting      = rx_abort && (state != IDLE);
        accept        = data_valid && !aborting;
        window_full   = (fill == 3'd4);
        cnt_next      = (byte_cnt >= LEN_SAT) ? byte_cnt : byte_cnt + 16'd1;
        crc_next      = window_full ? crc_byte(crc_reg, sr[3]) : crc_reg;
        fcs_rx        = {sr[2], sr[1], sr[0], data_in};
        over_max      = (cnt_next > LEN_MAX) || (state == DISCARD);
        // fill >= 3 means this byte completes at least a 4-byte frame
        fcs_match     = (fill >= 3'd3) && !over_max && (~crc_next == fcs_rx);
        len_bad       = (fill < 3'd3) || (cnt_next < LEN_MIN) || (cnt_next > LEN_MAX);
        abort_len_bad = (byte_cnt < LEN_MIN) || (byte_cnt > LEN_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            crc_reg    <= '1;
            byte_cnt   <= '0;
            fill       <= '0;
            sr         <= '{default: '0};
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            crc_ok     <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
            frame_len  <= '0;
        end else begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            crc_ok     <= 1'b0;
            crc_err    <= 1'b0;
            len_err    <= 1'b0;
            frame_len  <= '0;

            if (aborting) begin
                frame_done <= 1'b1;
                crc_err    <= 1'b1;
                len_err    <= abort_len_bad;
                frame_len  <= byte_cnt;
                state      <= IDLE;
                crc_reg    <= '1;
                byte_cnt   <= '0;
                fill       <= '0;
                sr         <= '{default: '0};
            end else if (accept) begin
`ifdef RX_FCS_PASS_EN
                if (!over_max) begin
                    out_data <= data_in;
                end
                out_valid <= !over_max;
                out_last  <= !over_max && data_last;
`else
                if (window_full && !over_max) begin
                    out_data <= sr[3];
                end
                out_valid <= window_full && !over_max;
                out_last  <= window_full && !over_max && data_last;
`endif
                sr[3] <= sr[2];
                sr[2] <= sr[1];
                sr[1] <= sr[0];
                sr[0] <= data_in;

                if (data_last) begin
                    frame_done <= 1'b1;
                    crc_ok     <= fcs_match;
                    crc_err    <= !fcs_match;
                    len_err    <= len_bad;
                    frame_len  <= cnt_next;
                    state      <= IDLE;
                    crc_reg    <= '1;
                    byte_cnt   <= '0;
                    fill       <= '0;
                    sr         <= '{default: '0};
                end else begin
                    crc_reg  <= crc_next;
                    byte_cnt <= cnt_next;
                    if (!window_full) begin
                        fill <= fill + 3'd1;
                    end
                    state <= over_max ? DISCARD : RECV;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_crc_checker.sv
// Scoreboard bench for rx_crc_checker: random frames against a frame-level reference model.
module tb_rx_crc_checker;

    localparam int MIN_F  = 5;
    localparam int MAX_F  = 1518;
    localparam int MIN_D  = 64;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    typedef logic [7:0] bq_t [$];
    typedef struct packed { logic [7:0] d; logic l; } out_t;
    typedef struct packed { logic ok; logic err; logic lerr; logic [15:0] len; } stat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data_in = '0;
    logic        data_valid = 1'b0;
    logic        data_last = 1'b0;
    logic        rx_abort = 1'b0;

    logic [7:0]  out_data, out_data_d;
    logic        out_valid, out_valid_d, out_last, out_last_d;
    logic        frame_done, frame_done_d, crc_ok, crc_ok_d, crc_err, crc_err_d;
    logic        len_err, len_err_d;
    logic [15:0] frame_len, frame_len_d;

    out_t  exp_out [$];
    stat_t exp_stat [$];
    stat_t exp_stat_def [$];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    rx_crc_checker #(.MIN_FRAME(MIN_F), .MAX_FRAME(MAX_F)) u_dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_last(data_last), .rx_abort(rx_abort),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .frame_done(frame_done), .crc_ok(crc_ok), .crc_err(crc_err),
        .len_err(len_err), .frame_len(frame_len)
    );

    rx_crc_checker u_dut_def (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_last(data_last), .rx_abort(rx_abort),
        .out_data(out_data_d), .out_valid(out_valid_d), .out_last(out_last_d),
        .frame_done(frame_done_d), .crc_ok(crc_ok_d), .crc_err(crc_err_d),
        .len_err(len_err_d), .frame_len(frame_len_d)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // CRC-32/BZIP2 of the first n bytes of a message
    function automatic logic [31:0] crc_ref(input bq_t m, input int n);
        logic [31:0] c = '1;
        for (int i = 0; i < n; i++)
            for (int b = 7; b >= 0; b--)
                c = (c[31] ^ m[i][b]) ? ((c << 1) ^ POLY) : (c << 1);
        return ~c;
    endfunction

    task automatic make_frame(input int plen, input bit corrupt, output bq_t f);
        logic [31:0] c;
        int idx;
        f = {};
        for (int i = 0; i < plen; i++) f.push_back(8'($urandom));
        c = crc_ref(f, plen);
        f.push_back(c[31:24]); f.push_back(c[23:16]); f.push_back(c[15:8]); f.push_back(c[7:0]);
        if (corrupt) begin
            idx = $urandom_range(0, f.size() - 1);
            f[idx] = f[idx] ^ 8'(1 << $urandom_range(0, 7));
        end
    endtask

    // kind 0: frame ends with data_last after k bytes; 1: rx_abort after k bytes; 2: rst after k bytes
    task automatic push_expect(input bq_t b, input int kind, input int k);
`ifdef RX_FCS_PASS_EN
        int lat = 1;
`else
        int lat = 5;
`endif
        int len;
        bit seen, ok, lerr, lerr_d;
        logic [31:0] fcs;
        for (int i = 0; i < k; i++) begin
            seen = (i + lat <= k) && (i + lat <= MAX_F);
            if (kind == 2) seen = seen && (i + lat <= k - 1);
            if (seen) exp_out.push_back('{d: b[i], l: (kind == 0) && (i + lat == k)});
        end
        if (kind == 2) return;
        len = (k > MAX_F) ? MAX_F + 1 : k;
        ok = 1'b0;
        if (kind == 0 && k >= 4 && k <= MAX_F) begin
            fcs = {b[k-4], b[k-3], b[k-2], b[k-1]};
            ok = (crc_ref(b, k - 4) == fcs);
        end
        lerr   = (len < MIN_F) || (len > MAX_F) || (kind == 0 && k < 4);
        lerr_d = (len < MIN_D) || (len > MAX_F) || (kind == 0 && k < 4);
        exp_stat.push_back('{ok: ok, err: !ok, lerr: lerr, len: 16'(len)});
        exp_stat_def.push_back('{ok: ok, err: !ok, lerr: lerr_d, len: 16'(len)});
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 0);
        check({tag, "_out_last"}, {31'd0, out_last}, 0);
        check({tag, "_out_data"}, {24'd0, out_data}, 0);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 0);
        check({tag, "_status"}, {13'd0, crc_ok, crc_err, len_err, frame_len}, 0);
        check({tag, "_def_frame_done"}, {31'd0, frame_done_d}, 0);
    endtask

    task automatic drive_frame(input bq_t b, input int kind, input int k, input int gap, input bit abort_first);
        push_expect(b, kind, k);
        for (int i = 0; i < k; i++) begin
            data_in    = b[i];
            data_valid = 1'b1;
            data_last  = (kind == 0) && (i == k - 1);
            rx_abort   = abort_first && (i == 0);
            @(posedge clk); #1;
        end
        data_valid = 1'b0; data_last = 1'b0; rx_abort = 1'b0;
        if (kind == 1) begin
            rx_abort   = 1'b1;
            data_valid = 1'($urandom);
            data_in    = 8'($urandom);
            @(posedge clk); #1;
            rx_abort = 1'b0; data_valid = 1'b0;
        end
        if (kind == 2) begin
            data_in = b[k]; data_valid = 1'b1; rst = 1'b1;
            @(posedge clk); #1;
            data_valid = 1'b0;
            check_zero_outputs("midreset");
            rst = 1'b0;
            @(posedge clk); #1;
        end
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    // Monitor: pops expectations whenever the DUTs present output
    always @(negedge clk) begin
        out_t  eo;
        stat_t es;
        if (!rst) begin
            if (out_valid) begin
                if (exp_out.size() == 0) check("out_unexpected", {23'd0, out_data, out_last}, 32'hFFFF_FFFF);
                else begin
                    eo = exp_out.pop_front();
                    check("out_data", {24'd0, out_data}, {24'd0, eo.d});
                    check("out_last", {31'd0, out_last}, {31'd0, eo.l});
                end
            end
            if (frame_done) begin
                if (exp_stat.size() == 0) check("stat_unexpected", {31'd0, frame_done}, 0);
                else begin
                    es = exp_stat.pop_front();
                    check("crc_ok", {31'd0, crc_ok}, {31'd0, es.ok});
                    check("crc_err", {31'd0, crc_err}, {31'd0, es.err});
                    check("len_err", {31'd0, len_err}, {31'd0, es.lerr});
                    check("frame_len", {16'd0, frame_len}, {16'd0, es.len});
                end
            end else begin
                check("status_idle", {13'd0, crc_ok, crc_err, len_err, frame_len}, 0);
            end
            if (frame_done_d) begin
                if (exp_stat_def.size() == 0) check("def_stat_unexpected", {31'd0, frame_done_d}, 0);
                else begin
                    es = exp_stat_def.pop_front();
                    check("def_crc_ok", {31'd0, crc_ok_d}, {31'd0, es.ok});
                    check("def_len_err", {31'd0, len_err_d}, {31'd0, es.lerr});
                    check("def_frame_len", {16'd0, frame_len_d}, {16'd0, es.len});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t f, g;
        int  plen, kind, k;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // published check vector "123456789" -> FC891918
        f = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
             8'hFC, 8'h89, 8'h19, 8'h18};
        drive_frame(f, 0, 13, 2, 1'b0);
        f[12] = 8'h19;
        drive_frame(f, 0, 13, 1, 1'b0);

        rx_abort = 1'b1;
        @(posedge clk); #1;
        rx_abort = 1'b0;

        make_frame(30, 1'b0, f); drive_frame(f, 0, f.size(), 0, 1'b0);
        make_frame(25, 1'b0, f); drive_frame(f, 0, f.size(), 0, 1'b0);
        make_frame(30, 1'b0, f); drive_frame(f, 1, 20, 3, 1'b0);

        make_frame(1596, 1'b0, f); drive_frame(f, 0, 1600, 2, 1'b0);
        make_frame(1514, 1'b0, f); drive_frame(f, 0, 1518, 0, 1'b0);
        make_frame(1515, 1'b0, f); drive_frame(f, 0, 1519, 1, 1'b0);

        make_frame(16, 1'b0, f); drive_frame(f, 2, 6, 0, 1'b0);
        make_frame(20, 1'b0, f); drive_frame(f, 0, f.size(), 1, 1'b0);

        for (int n = 1; n <= 3; n++) begin
            make_frame(0, 1'b0, f);
            drive_frame(f, 0, n, n - 1, 1'b0);
        end
        g = {8'h00, 8'h00, 8'h00, 8'h00};
        drive_frame(g, 0, 4, 0, 1'b0);
        make_frame(0, 1'b0, f); drive_frame(f, 0, 4, 0, 1'b1);
        make_frame(1, 1'b0, f); drive_frame(f, 0, 5, 1, 1'b0);
        make_frame(10, 1'b0, f); drive_frame(f, 1, 1, 0, 1'b0);
        make_frame(10, 1'b0, f); drive_frame(f, 1, 2, 2, 1'b0);

        for (int r = 0; r < 40; r++) begin
            plen = $urandom_range(0, 70);
            make_frame(plen, ($urandom_range(0, 3) == 0), f);
            kind = ($urandom_range(0, 9) == 0) ? 1 : 0;
            k = (kind == 0) ? f.size() : $urandom_range(1, f.size());
            drive_frame(f, kind, k, $urandom_range(0, 3), 1'($urandom_range(0, 3) == 0));
        end

        for (int c = 0; c < 200 && (exp_out.size() != 0 || exp_stat.size() != 0 || exp_stat_def.size() != 0); c++)
            @(posedge clk);
        #1;
        check("drain_out", exp_out.size(), 0);
        check("drain_stat", exp_stat.size(), 0);
        check("drain_stat_def", exp_stat_def.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
